exc_seq: RTL

EXC_SEQ -- requirements
Module: exc_seq

---
 rtl/exc_seq_if.sv | 32 +++
 rtl/exc_seq.sv | 125 ++++++++++++
 2 files changed

// File: rtl/exc_seq_if.sv
// Exception sequencer bus: request/mask/PC inputs, EPC, vector-fetch and PC-load outputs.
// The slave modport is the sequencer's view; master is the core/memory side.
interface exc_seq_if #(
    parameter int NUM_SRC = 3,
    parameter int ADDR_W  = 32
);
    logic [NUM_SRC-1:0] exc_req;
    logic [NUM_SRC-1:0] exc_mask;
    logic [ADDR_W-1:0]  pc_in;
    logic [7:0]         mem_rdata;
    logic               busy;
    logic               epc_write;
    logic [ADDR_W-1:0]  epc_data;
    logic               mem_read;
    logic [ADDR_W-1:0]  mem_addr;
    logic               pc_load;
    logic [ADDR_W-1:0]  pc_value;
    logic [NUM_SRC-1:0] cause;
    logic               done;

    modport slave (
        input  exc_req, exc_mask, pc_in, mem_rdata,
        output busy, epc_write, epc_data, mem_read, mem_addr,
               pc_load, pc_value, cause, done
    );

    modport master (
        output exc_req, exc_mask, pc_in, mem_rdata,
        input  busy, epc_write, epc_data, mem_read, mem_addr,
               pc_load, pc_value, cause, done
    );
endinterface

// File: rtl/exc_seq.sv
// Exception entry sequencer: picks the highest-priority unmasked request, saves EPC,
// fetches the vector byte from memory and loads it into the PC.
module exc_seq #(
    parameter int NUM_SRC  = 3,
    parameter int ADDR_W   = 32,
    parameter int VEC_BASE = 253,
    parameter int MEM_WAIT = 2
) (
    input  logic       clk,
    input  logic       reset,
    exc_seq_if.slave   bus
);
    localparam int CNT_W = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((MEM_WAIT > 0) ? MEM_WAIT - 1 : 0);

    typedef enum logic [2:0] {
        IDLE, CAPTURE, MEMREQ, WAIT, LOAD, DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [NUM_SRC-1:0] pending;
    logic [ADDR_W-1:0]  vec_addr;

    // Lowest set index wins, so scan downwards and let the last hit stick.
    function automatic logic [NUM_SRC-1:0] pick_lowest(input logic [NUM_SRC-1:0] v);
        logic [NUM_SRC-1:0] r;
        r = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (v[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    assign pending = bus.exc_req & ~bus.exc_mask;

    always_comb begin
        vec_addr = ADDR_W'(VEC_BASE);
        for (int i = 0; i < NUM_SRC; i++) begin
            if (bus.cause[i]) vec_addr = ADDR_W'(VEC_BASE) + ADDR_W'(i);
        end
    end

    // Outputs are registered alongside the state, so each strobe is valid exactly
    // while the state register holds its matching state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= '0;
            bus.cause     <= '0;
            bus.busy      <= 1'b0;
            bus.epc_write <= 1'b0;
            bus.epc_data  <= '0;
            bus.mem_read  <= 1'b0;
            bus.mem_addr  <= '0;
            bus.pc_load   <= 1'b0;
            bus.pc_value  <= '0;
            bus.done      <= 1'b0;
        end else begin
            bus.busy      <= 1'b1;
            bus.epc_write <= 1'b0;
            bus.epc_data  <= '0;
            bus.mem_read  <= 1'b0;
            bus.mem_addr  <= '0;
            bus.pc_load   <= 1'b0;
            bus.pc_value  <= '0;
            bus.done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (|pending) begin
                        state         <= CAPTURE;
                        bus.cause     <= pick_lowest(pending);
                        bus.epc_write <= 1'b1;
                        bus.epc_data  <= bus.pc_in - ADDR_W'(4);
                    end else begin
                        bus.busy <= 1'b0;
                    end
                end
                CAPTURE: begin
                    state        <= MEMREQ;
                    bus.mem_read <= 1'b1;
                    bus.mem_addr <= vec_addr;
                end
                MEMREQ: begin
                    if (MEM_WAIT > 0) begin
                        state        <= WAIT;
                        cnt          <= CNT_INIT;
                        bus.mem_read <= 1'b1;
                        bus.mem_addr <= vec_addr;
                    end else begin
                        state        <= LOAD;
                        bus.pc_load  <= 1'b1;
                        bus.pc_value <= ADDR_W'(bus.mem_rdata);
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state        <= LOAD;
                        bus.pc_load  <= 1'b1;
                        bus.pc_value <= ADDR_W'(bus.mem_rdata);
                    end else begin
                        cnt          <= cnt - 1'b1;
                        bus.mem_read <= 1'b1;
                        bus.mem_addr <= vec_addr;
                    end
                end
                LOAD: begin
                    state    <= DONE;
                    bus.done <= 1'b1;
                end
                DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule
